// File: rtl/hex_display_driver.sv
// hex_display_driver
//   Drives NUM_DIGITS seven-segment digits from a held hexadecimal value.
//   A load captures the value, the per-digit blink mask and the leading-zero
//   blanking enable. A free-running counter produces the blink phase.
//   Each digit shows one of four things, in this order of priority:
//   lamp test (all segments lit), blink blank, leading-zero blank, or the
//   decoded nibble.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   hexval      in   [4*NUM_DIGITS-1:0] value; nibble k drives digit k
//   load        in   sample hexval/blink_mask/lz_blank on this edge
//   blink_mask  in   [NUM_DIGITS-1:0] per-digit blink enable
//   lz_blank    in   leading-zero blanking enable
//   lamp_test   in   live input, forces every segment lit
//   segs        out  [7*NUM_DIGITS-1:0] registered segments, gfedcba per digit
//   loaded      out  one-cycle acknowledge of an accepted load
module hex_display_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] hexval,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank,
  input  logic                    lamp_test,
  output logic [7*NUM_DIGITS-1:0] segs,
  output logic                    loaded
);

  // A one-bit counter is kept for BLINK_DIV=1 so the vector is never zero-width.
  localparam int              CNT_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0]      SEG_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0]      SEG_ALL   = ACTIVE_LOW ? 7'h00 : 7'h7F;

  // Standard hex decode, written active-low and inverted for active-high parts.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return ACTIVE_LOW ? seg : ~seg;
  endfunction

  logic [4*NUM_DIGITS-1:0] held_value;
  logic [NUM_DIGITS-1:0]   held_mask;
  logic                    held_lz;
  logic [CNT_W-1:0]        blink_cnt;
  logic                    blink_phase;
  logic [NUM_DIGITS-1:0]   lz_hide;
  logic                    nz_seen;
  logic [7*NUM_DIGITS-1:0] next_segs;

  // Held display state: captured on load, otherwise kept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_value <= '0;
      held_mask  <= '0;
      held_lz    <= 1'b0;
    end else if (load) begin
      held_value <= hexval;
      held_mask  <= blink_mask;
      held_lz    <= lz_blank;
    end else begin
      held_value <= held_value;
      held_mask  <= held_mask;
      held_lz    <= held_lz;
    end
  end

  // Free-running blink divider; the phase flips each time the count wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + CNT_W'(1);
      blink_phase <= blink_phase;
    end
  end

  // Per-digit output selection. Leading-zero detection scans from the top
  // digit down; digit 0 is always shown so a zero value still reads "0".
  always_comb begin
    lz_hide   = '0;
    nz_seen   = 1'b0;
    next_segs = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (held_value[4*k +: 4] != 4'h0) begin
        nz_seen = 1'b1;
      end else begin
        nz_seen = nz_seen;
      end
      lz_hide[k] = held_lz && !nz_seen && (k != 0);
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (lamp_test) begin
        next_segs[7*k +: 7] = SEG_ALL;
      end else if (blink_phase && held_mask[k]) begin
        next_segs[7*k +: 7] = SEG_BLANK;
      end else if (lz_hide[k]) begin
        next_segs[7*k +: 7] = SEG_BLANK;
      end else begin
        next_segs[7*k +: 7] = decode(held_value[4*k +: 4]);
      end
    end
  end

  // Output register and load acknowledge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      segs   <= {NUM_DIGITS{SEG_BLANK}};
      loaded <= 1'b0;
    end else begin
      segs   <= next_segs;
      loaded <= load;
    end
  end

endmodule

// File: tb/tb_hex_display_driver.sv
module tb_hex_display_driver;

  localparam int ND  = 6;
  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] hexval;
  logic        load;
  logic [5:0]  blink_mask;
  logic        lz_blank;
  logic        lamp_test;
  logic [41:0] segs;
  logic        loaded;
  logic [6:0]  segs1;
  logic        loaded1;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference state: what the display should hold after the edges so far.
  logic [23:0] m_val;
  logic [5:0]  m_mask;
  logic        m_lz;
  int          n_edges;
  logic [41:0] exp_segs;
  logic [6:0]  exp_segs1;
  logic        exp_loaded;

  // Active-low gfedcba patterns for hex 0..F.
  logic [6:0] al_table [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clock = ~clock;

  hex_display_driver #(.NUM_DIGITS(ND), .BLINK_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .hexval(hexval), .load(load),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .lamp_test(lamp_test),
    .segs(segs), .loaded(loaded)
  );

  hex_display_driver #(.NUM_DIGITS(1), .BLINK_DIV(1), .ACTIVE_LOW(1'b0)) dut1 (
    .clock(clock), .reset(reset), .hexval(hexval[3:0]), .load(load),
    .blink_mask(blink_mask[0:0]), .lz_blank(lz_blank), .lamp_test(lamp_test),
    .segs(segs1), .loaded(loaded1)
  );

  function automatic logic [41:0] model_display(input logic [23:0] val, input logic [5:0] mask,
                                                input logic lz, input logic phase, input logic lamp,
                                                input int nd, input bit al);
    logic [41:0] r;
    logic [6:0]  d;
    logic [3:0]  nib;
    r = '0;
    for (int k = 0; k < nd; k++) begin
      nib = 4'((val >> (4 * k)) & 24'hF);
      if (lamp) d = 7'h00;
      else if (phase && mask[k]) d = 7'h7F;
      else if (lz && k > 0 && (val >> (4 * k)) == 24'd0) d = 7'h7F;
      else d = al_table[nib];
      r[7*k +: 7] = al ? d : ~d;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: predict the outputs from pre-edge state, then compare at the negedge.
  task automatic tick(input string tag);
    @(posedge clock);
    exp_segs   = model_display(m_val, m_mask, m_lz, 1'((n_edges / DIV) % 2), lamp_test, ND, 1'b1);
    exp_segs1  = 7'(model_display(m_val & 24'hF, m_mask & 6'h1, m_lz, 1'(n_edges % 2), lamp_test, 1, 1'b0));
    exp_loaded = load;
    if (load) begin
      m_val  = hexval;
      m_mask = blink_mask;
      m_lz   = lz_blank;
    end
    n_edges++;
    @(negedge clock);
    check({tag, "/segs"},    64'(segs),    64'(exp_segs));
    check({tag, "/segs1"},   64'(segs1),   64'(exp_segs1));
    check({tag, "/loaded"},  64'(loaded),  64'(exp_loaded));
    check({tag, "/loaded1"}, 64'(loaded1), 64'(exp_loaded));
  endtask

  task automatic model_reset();
    m_val   = '0;
    m_mask  = '0;
    m_lz    = 1'b0;
    n_edges = 0;
  endtask

  // Assert reset at a negedge, verify the asynchronous effect, hold one edge, release.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "/async_segs"},   64'(segs),    64'({6{7'h7F}}));
    check({tag, "/async_segs1"},  64'(segs1),   64'(7'h00));
    check({tag, "/async_loaded"}, 64'(loaded),  64'(1'b0));
    model_reset();
    @(negedge clock);
    check({tag, "/held_loaded"},  64'(loaded),  64'(1'b0));
    check({tag, "/held_segs"},    64'(segs),    64'({6{7'h7F}}));
    load  = 1'b0;
    reset = 1'b0;
  endtask

  int blank_count;

  initial begin
    reset      = 1'b0;
    hexval     = '0;
    load       = 1'b0;
    blink_mask = '0;
    lz_blank   = 1'b0;
    lamp_test  = 1'b0;
    model_reset();
    @(negedge clock);
    do_reset("reset");

    // Basic decode and two-edge latency.
    hexval = 24'h00A1F8; lz_blank = 1'b0; blink_mask = 6'h00; load = 1'b1;
    tick("dec_load");
    check("dec_ack", 64'(loaded), 64'(1'b1));
    load = 1'b0;
    tick("dec_show");
    check("dec_digits", 64'(segs), 64'({7'h40, 7'h40, 7'h08, 7'h79, 7'h0E, 7'h00}));

    // Leading-zero blanking.
    hexval = 24'h000000; lz_blank = 1'b1; load = 1'b1;
    tick("lz0_load");
    load = 1'b0;
    tick("lz0_show");
    check("lz_all_zero", 64'(segs), 64'({{5{7'h7F}}, 7'h40}));
    hexval = 24'h000100; load = 1'b1;
    tick("lz1_load");
    load = 1'b0;
    tick("lz1_show");
    check("lz_inner_zero", 64'(segs), 64'({7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}));

    // Blink on digit 0 only; any 16 consecutive edges have 8 blank-phase edges.
    hexval = 24'h123456; lz_blank = 1'b0; blink_mask = 6'h01; load = 1'b1;
    tick("blink_load");
    load = 1'b0;
    blank_count = 0;
    for (int i = 0; i < 16; i++) begin
      tick("blink_run");
      check("blink_steady", 64'(segs[41:7]), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12}));
      if (segs[6:0] === 7'h7F) blank_count++;
    end
    check("blink_blank_count", 64'(blank_count), 64'(8));

    // Lamp test overrides blink and lz, then releases back to the display.
    hexval = 24'h000012; lz_blank = 1'b1; blink_mask = 6'h3F; load = 1'b1;
    tick("lamp_load");
    load = 1'b0;
    tick("lamp_pre");
    lamp_test = 1'b1;
    tick("lamp_on");
    check("lamp_all_lit", 64'(segs), 64'({6{7'h00}}));
    lamp_test = 1'b0;
    for (int i = 0; i < 6; i++) tick("lamp_off");

    // Back-to-back loads, last one wins.
    lz_blank = 1'b0; blink_mask = 6'h00;
    hexval = 24'h111111; load = 1'b1; tick("b2b_1");
    hexval = 24'h222222; tick("b2b_2");
    hexval = 24'h333333; tick("b2b_3");
    load = 1'b0;
    tick("b2b_show");
    check("b2b_final", 64'(segs), 64'({6{7'h30}}));

    // Reset on the cycle of the third load discards it.
    hexval = 24'h111111; load = 1'b1; tick("rl_1");
    hexval = 24'h222222; tick("rl_2");
    hexval = 24'h333333;
    do_reset("rl_reset");
    tick("rl_after");
    check("rl_held_zero", 64'(segs), 64'({6{7'h40}}));

    // Randomised traffic, including occasional mid-stream resets.
    for (int i = 0; i < 300; i++) begin
      hexval     = 24'($urandom);
      if ($urandom_range(0, 1) == 0) hexval = hexval & 24'h000F0F;
      blink_mask = 6'($urandom);
      lz_blank   = 1'($urandom);
      load       = ($urandom_range(0, 2) == 0);
      lamp_test  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) do_reset("rand_reset");
      else tick("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
